// File: rtl/datapath_pipe.sv
// ============================================================================
//  Module      : datapath_pipe
//  Description : Two-stage pipelined datapath: register file, operand muxes
//                with writeback bypass, function unit with registered flags,
//                writeback stage and a req/ack data-memory port that stalls
//                the instruction stream.
//  Option      : DATAPATH_PIPE_R0_ZERO_EN - register 0 hardwired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_pipe #(
   parameter int WIDTH = 8,
   parameter int NREG  = 8,
   parameter int AW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    AA,
   input  logic [AW-1:0]    BA,
   input  logic [AW-1:0]    DA,
   input  logic [3:0]       FS,
   input  logic [WIDTH-1:0] CI,
   input  logic             MB,
   input  logic             MD,
   input  logic             MW,
   input  logic             LE,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] BusD,
   output logic             wb_valid,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V,
   input  logic [AW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] regs [NREG];

   logic [WIDTH-1:0] wb_data;
   logic [AW-1:0]    wb_dest;

   logic [AW-1:0]    pend_da;
   logic             pend_le;
   logic             pend_load;

   logic             accept;
   logic             is_mem;
   logic             rf_we;
   logic             byp_a;
   logic             byp_b;
   logic [WIDTH-1:0] a_rf;
   logic [WIDTH-1:0] b_rf;
   logic [WIDTH-1:0] a_op;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] b_op;

   logic [WIDTH-1:0] add_op2;
   logic             add_cin;
   logic [WIDTH:0]   sum;
   logic             arith;
   logic [WIDTH-1:0] alu_f;
   logic             n_next;
   logic             z_next;
   logic             c_next;
   logic             v_next;

   assign in_ready = (state == ST_RUN);
   assign accept   = in_valid & in_ready;
   assign is_mem   = MD | MW;
   assign BusD     = wb_data;

   // ------------------------------------------------------------------
   // Register file read, write enable and bypass selection
   // ------------------------------------------------------------------
`ifdef DATAPATH_PIPE_R0_ZERO_EN
   assign rf_we    = wb_valid & (wb_dest != '0);
   assign byp_a    = wb_valid & (wb_dest == AA) & (AA != '0);
   assign byp_b    = wb_valid & (wb_dest == BA) & (BA != '0);
   assign a_rf     = (AA == '0) ? '0 : regs[AA];
   assign b_rf     = (BA == '0) ? '0 : regs[BA];
   assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];
`else
   assign rf_we    = wb_valid;
   assign byp_a    = wb_valid & (wb_dest == AA);
   assign byp_b    = wb_valid & (wb_dest == BA);
   assign a_rf     = regs[AA];
   assign b_rf     = regs[BA];
   assign dbg_data = regs[dbg_sel];
`endif

   assign a_op  = byp_a ? wb_data : a_rf;
   assign b_reg = byp_b ? wb_data : b_rf;
   assign b_op  = MB ? CI : b_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (rf_we) begin
         regs[wb_dest] <= wb_data;
      end
   end

   // ------------------------------------------------------------------
   // Function unit: every arithmetic code maps onto A + op2 + cin
   // ------------------------------------------------------------------
   always_comb begin
      add_op2 = '0;
      add_cin = 1'b0;
      case (FS[2:0])
         3'b001:  add_cin = 1'b1;
         3'b010:  add_op2 = b_op;
         3'b011:  begin add_op2 = b_op;  add_cin = 1'b1; end
         3'b100:  add_op2 = ~b_op;
         3'b101:  begin add_op2 = ~b_op; add_cin = 1'b1; end
         3'b110:  add_op2 = '1;
         default: begin add_op2 = '0;    add_cin = 1'b0; end
      endcase
   end

   assign sum   = {1'b0, a_op} + {1'b0, add_op2} + {{WIDTH{1'b0}}, add_cin};
   assign arith = ~FS[3];

   always_comb begin
      alu_f = '0;
      case (FS)
         4'b1000: alu_f = a_op & b_op;
         4'b1001: alu_f = a_op | b_op;
         4'b1010: alu_f = a_op ^ b_op;
         4'b1011: alu_f = ~a_op;
         4'b1100: alu_f = b_op;
         4'b1101: alu_f = {1'b0, b_op[WIDTH-1:1]};
         4'b1110: alu_f = {b_op[WIDTH-2:0], 1'b0};
         4'b1111: alu_f = '0;
         default: alu_f = sum[WIDTH-1:0];
      endcase
   end

   assign n_next = alu_f[WIDTH-1];
   assign z_next = (alu_f == '0);
   assign c_next = arith & sum[WIDTH];
   assign v_next = arith & (a_op[WIDTH-1] == add_op2[WIDTH-1])
                         & (alu_f[WIDTH-1] != a_op[WIDTH-1]);

   // ------------------------------------------------------------------
   // Control FSM, writeback stage, memory port and flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RUN;
         wb_data   <= '0;
         wb_dest   <= '0;
         wb_valid  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         pend_da   <= '0;
         pend_le   <= 1'b0;
         pend_load <= 1'b0;
         N         <= 1'b0;
         Z         <= 1'b0;
         C         <= 1'b0;
         V         <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               wb_valid <= 1'b0;
               if (accept) begin
                  if (is_mem) begin
                     // A store takes precedence over MD
                     state     <= ST_MEM_WAIT;
                     mem_req   <= 1'b1;
                     mem_we    <= MW;
                     mem_addr  <= a_op;
                     mem_wdata <= b_op;
                     pend_da   <= DA;
                     pend_le   <= LE;
                     pend_load <= ~MW;
                  end else begin
                     wb_data  <= alu_f;
                     wb_dest  <= DA;
                     wb_valid <= LE;
                     N        <= n_next;
                     Z        <= z_next;
                     C        <= c_next;
                     V        <= v_next;
                  end
               end
            end
            ST_MEM_WAIT: begin
               wb_valid <= 1'b0;
               if (mem_ack) begin
                  state   <= ST_RUN;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (pend_load) begin
                     wb_data  <= mem_rdata;
                     wb_dest  <= pend_da;
                     wb_valid <= pend_le;
                  end
               end
            end
            default: begin
               state    <= ST_RUN;
               wb_valid <= 1'b0;
               mem_req  <= 1'b0;
               mem_we   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_datapath_pipe.sv
// ============================================================================
//  Module      : tb_datapath_pipe
//  Description : Scoreboard bench for datapath_pipe (honours
//                DATAPATH_PIPE_R0_ZERO_EN when defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_pipe;

   localparam int W  = 8;
   localparam int NR = 8;
   localparam int AW = 3;
`ifdef DATAPATH_PIPE_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] AA = '0, BA = '0, DA = '0, dbg_sel = '0;
   logic [3:0]    FS = '0;
   logic [W-1:0]  CI = '0;
   logic          MB = 1'b0, MD = 1'b0, MW = 1'b0, LE = 1'b0;
   logic          mem_req, mem_we;
   logic [W-1:0]  mem_addr, mem_wdata;
   logic          mem_ack = 1'b0;
   logic [W-1:0]  mem_rdata = '0;
   logic [W-1:0]  BusD, dbg_data;
   logic          wb_valid, N, Z, C, V;

   datapath_pipe #(.WIDTH(W), .NREG(NR)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .AA(AA), .BA(BA), .DA(DA), .FS(FS), .CI(CI), .MB(MB), .MD(MD),
      .MW(MW), .LE(LE), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .BusD(BusD), .wb_valid(wb_valid),
      .N(N), .Z(Z), .C(C), .V(V), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] mreg [NR];
   logic        mN = 0, mZ = 0, mC = 0, mV = 0;
   logic [W-1:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
      return (R0Z && a == 0) ? '0 : mreg[a];
   endfunction

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      if (!(R0Z && a == 0)) mreg[a] = d;
   endtask

   // Reference ALU using plain integer arithmetic for carry and overflow
   task automatic model_alu(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] f, output logic n, output logic z,
                            output logic c, output logic v);
      int op2, cin, us, ss, sa, so;
      op2 = 0; cin = 0;
      c = 0; v = 0;
      if (fs[3] == 1'b0) begin
         case (fs[2:0])
            3'd1: cin = 1;
            3'd2: op2 = int'(b);
            3'd3: begin op2 = int'(b); cin = 1; end
            3'd4: op2 = 255 - int'(b);
            3'd5: begin op2 = 255 - int'(b); cin = 1; end
            3'd6: op2 = 255;
            default: ;
         endcase
         us = int'(a) + op2 + cin;
         sa = (a >= 128) ? int'(a) - 256 : int'(a);
         so = (op2 >= 128) ? op2 - 256 : op2;
         ss = sa + so + cin;
         f  = us[W-1:0];
         c  = (us > 255);
         v  = (ss > 127) || (ss < -128);
      end else begin
         case (fs)
            4'b1000: f = a & b;
            4'b1001: f = a | b;
            4'b1010: f = a ^ b;
            4'b1011: f = ~a;
            4'b1100: f = b;
            4'b1101: f = b / 2;
            4'b1110: f = b * 2;
            default: f = '0;
         endcase
      end
      n = f[W-1];
      z = (f == 0);
   endtask

   // Writeback monitor: every register write must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && wb_valid) begin
         if (exp_q.size() == 0) check_eq("wb_unexpected", 1, 0);
         else check_eq("wb_busd", BusD, exp_q.pop_front());
      end
   end

   task automatic alu_op(input logic [AW-1:0] aa, input logic [AW-1:0] ba, input logic [AW-1:0] da,
                         input logic [3:0] fs, input logic [W-1:0] ci, input logic mb, input logic le);
      logic [W-1:0] a, b, f;
      a = rd(aa);
      b = mb ? ci : rd(ba);
      model_alu(fs, a, b, f, mN, mZ, mC, mV);
      if (le) begin
         exp_q.push_back(f);
         wr(da, f);
      end
      AA = aa; BA = ba; DA = da; FS = fs; CI = ci; MB = mb; LE = le;
      MD = 0; MW = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      check_eq("flags_nzcv", {N, Z, C, V}, {mN, mZ, mC, mV});
   endtask

   task automatic mem_op(input logic store, input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                         input logic [AW-1:0] da, input logic [W-1:0] ci, input logic mb,
                         input int waits, input logic [W-1:0] rdata, input logic abort);
      logic [W-1:0] ea, eb;
      ea = rd(aa);
      eb = mb ? ci : rd(ba);
      AA = aa; BA = ba; DA = da; CI = ci; MB = mb; LE = 1;
      MD = ~store; MW = store; FS = 4'b0000; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0; MD = 0; MW = 0;
      for (int i = 0; i < waits; i++) begin
         check_eq("mw_req", mem_req, 1);
         check_eq("mw_ready", in_ready, 0);
         check_eq("mw_addr", mem_addr, ea);
         check_eq("mw_we", mem_we, store);
         if (store) check_eq("mw_wdata", mem_wdata, eb);
         @(posedge clk); #1;
      end
      if (abort) begin
         rst = 1; #1;
         check_eq("rst_req_drop", mem_req, 0);
         check_eq("rst_ready", in_ready, 1);
         check_eq("rst_we", mem_we, 0);
         for (int i = 0; i < NR; i++) mreg[i] = '0;
         mN = 0; mZ = 0; mC = 0; mV = 0;
         @(posedge clk); #1;
         rst = 0;
      end else begin
         mem_ack = 1; mem_rdata = rdata;
         if (!store) begin
            exp_q.push_back(rdata);
            wr(da, rdata);
         end
         @(posedge clk); #1;
         mem_ack = 0; mem_rdata = '0;
         check_eq("ack_req_low", mem_req, 0);
         check_eq("ack_ready", in_ready, 1);
         check_eq("mem_flags", {N, Z, C, V}, {mN, mZ, mC, mV});
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++) begin
         dbg_sel = AW'(i); #1;
         check_eq(tag, dbg_data, rd(AW'(i)));
      end
   endtask

   initial begin
      for (int i = 0; i < NR; i++) mreg[i] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      check_eq("rst_ready", in_ready, 1);
      check_eq("rst_flags", {N, Z, C, V}, 4'b0000);
      check_eq("rst_busd", BusD, 0);
      check_eq("rst_mem", {mem_req, mem_we, wb_valid}, 3'b000);
      check_regs("rst_reg");

      // Dependent back-to-back ops through the bypass
      alu_op(3'd0, 3'd0, 3'd1, 4'b1100, 8'h05, 1'b1, 1'b1);
      alu_op(3'd1, 3'd1, 3'd2, 4'b0010, 8'h00, 1'b0, 1'b1);
      alu_op(3'd0, 3'd0, 3'd3, 4'b1100, 8'h80, 1'b1, 1'b1);
      alu_op(3'd3, 3'd0, 3'd7, 4'b0101, 8'h01, 1'b1, 1'b1);
      check_eq("sub_flags_0x7f", {N, Z, C, V}, 4'b0011);
      alu_op(3'd2, 3'd0, 3'd2, 4'b1111, 8'h00, 1'b1, 1'b0);
      check_eq("le0_zflag", Z, 1);
      @(posedge clk); #1;
      check_regs("after_alu");

      for (int k = 0; k < 24; k++) begin
         alu_op(AW'($urandom_range(0, NR-1)), AW'($urandom_range(0, NR-1)),
                AW'($urandom_range(0, NR-1)), 4'($urandom_range(0, 15)),
                W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0));
      end

      // Load R4 from address 0x10 with a 3-cycle ack delay, then consume it
      alu_op(3'd0, 3'd0, 3'd1, 4'b1100, 8'h10, 1'b1, 1'b1);
      mem_op(1'b0, 3'd1, 3'd0, 3'd4, 8'h00, 1'b0, 3, 8'hA5, 1'b0);
      alu_op(3'd4, 3'd0, 3'd3, 4'b0000, 8'h00, 1'b1, 1'b1);

      // Stray ack while running must be ignored
      mem_ack = 1; mem_rdata = 8'h5A;
      @(posedge clk); #1;
      mem_ack = 0;
      check_eq("stray_ack_ready", in_ready, 1);
      check_eq("stray_ack_req", mem_req, 0);

      // Store R5=0x3C at R6=0x20, completed then aborted by reset
      alu_op(3'd0, 3'd0, 3'd5, 4'b1100, 8'h3C, 1'b1, 1'b1);
      alu_op(3'd0, 3'd0, 3'd6, 4'b1100, 8'h20, 1'b1, 1'b1);
      mem_op(1'b1, 3'd6, 3'd5, 3'd1, 8'h00, 1'b0, 2, 8'h00, 1'b0);
      @(posedge clk); #1;
      check_regs("after_store");
      mem_op(1'b1, 3'd6, 3'd5, 3'd1, 8'h00, 1'b0, 2, 8'h00, 1'b1);
      check_eq("post_rst_ready", in_ready, 1);
      check_regs("post_rst_reg");

      // Register 0 behaviour (hardwired zero only when the option is on)
      alu_op(3'd0, 3'd0, 3'd0, 4'b1100, 8'hFF, 1'b1, 1'b1);
      alu_op(3'd0, 3'd0, 3'd1, 4'b0001, 8'h00, 1'b1, 1'b1);
      @(posedge clk); #1;
      dbg_sel = 3'd1; #1;
      check_eq("r0_r1_value", dbg_data, R0Z ? 8'h01 : 8'h00);
      check_regs("final_reg");

      repeat (3) @(posedge clk);
      #1 check_eq("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      check_eq("timeout", 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle 8x8 datapath.
- Contains:
  - a register file of NREG x WIDTH;
  - A/B operand read with constant-in mux (MB);
  - a function unit with registered status flags;
  - a writeback stage with bypass to the operands;
  - a req/ack memory port for loads and stores, which stalls the instruction stream.
- Sits between the microsequencer (in_valid/in_ready stream) and the data memory.

Parameters:
- WIDTH, 8, datapath and register width (>=4)
- NREG, 8, number of registers (power of two, >=2)
- AW, $clog2(NREG), register address width (derived, do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  datapath accepts instruction this cycle
- AA  in  AW  A operand register select
- BA  in  AW  B operand register select
- DA  in  AW  destination register select
- FS  in  4  function select
- CI  in  WIDTH  constant input
- MB  in  1  1: B=CI, 0: B=R[BA]
- MD  in  1  1: load (dest <- memory), 0: dest <- F
- MW  in  1  1: store R[BA]/CI to memory at A (MD ignored)
- LE  in  1  register write enable
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  request is write
- mem_addr  out  WIDTH  address (A operand)
- mem_wdata  out  WIDTH  store data (B operand)
- mem_ack  in  1  request complete; mem_rdata valid this cycle
- mem_rdata  in  WIDTH  load data
- BusD  out  WIDTH  WB stage data
- wb_valid  out  1  WB stage writes a register this cycle
- N, Z, C, V  out  1 each  registered flags
- dbg_sel  in  AW  debug read select
- dbg_data  out  WIDTH  R[dbg_sel], combinational from the register file (no bypass)

Behaviour:
- Reset:
  - All registers are 0; BusD=0.
  - wb_valid, mem_req, mem_we, N, Z, C, V are all 0.
  - State is RUN.
- Accept: an instruction is accepted on an edge where in_valid&in_ready.
- in_ready:
  - 1 in RUN.
  - 0 in MEM_WAIT.
- Operands:
  - A = R[AA]; B = MB ? CI : R[BA].
  - Bypass: if wb_valid and the WB destination equals AA (or BA with MB=0), the WB data is used instead.
- ALU op (MD=0, MW=0):
  - F is computed in the accept cycle.
  - WB register <= {F, DA, LE} at the edge.
  - R[DA] <= F at the following edge.
  - Latency: 2 edges; back-to-back dependent ops need no stall because of the bypass.
- FS encoding, mod 2^WIDTH:
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A-B; 0110 A-1; 0111 A.
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 B>>1 (zero-fill); 1110 B<<1; 1111 0.
- Flags, updated at the accept edge of ALU ops only:
  - N = F[WIDTH-1]; Z = (F==0).
  - C = carry out of the arithmetic codes 0000-0111; 0 for the others.
  - V = signed overflow for 0000-0111; 0 for the others.
- FSM RUN -> MEM_WAIT on an accepted load (MD=1) or store (MW=1):
  - mem_req=1 from the next cycle.
  - mem_addr = A and mem_wdata = B are latched.
  - mem_we = MW.
  - DA and LE are latched.
  - The WB stage drains normally on this edge.
- MEM_WAIT:
  - Outputs are held stable until mem_ack.
  - On mem_ack: mem_req=0 at that edge, return to RUN.
  - Load: WB register <= {mem_rdata, DA, LE}. Store: wb_valid=0.
  - Flags are unchanged by loads and stores.
- mem_ack outside MEM_WAIT is ignored.
- LE=0: the instruction executes and sets flags; wb_valid=0; no register is written.
- Simultaneous writeback and operand read of the same register: bypass value wins. The register file is written once.
- Reset mid-MEM_WAIT: mem_req drops immediately (async); the pending instruction is discarded.

Optional Feature:
- Macro DATAPATH_PIPE_R0_ZERO_EN.
- Defined:
  - R0 is hardwired to 0; writes to R0 are discarded (wb_valid still pulses).
  - Bypass never applies to register 0; dbg_data for sel=0 is 0.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset, then read all registers via dbg_sel -> every value 0; flags 0; in_ready=1.
- Write R1<-CI=0x05 (FS=1100, MB=1, LE=1), then the next cycle R2<-R1+R1 (FS=0010) -> R2=0x0A; exercises the bypass with no stall.
- R3=0x80, FS=0101 with B=CI=0x01 -> F=0x7F, V=1, C=1, N=0, Z=0.
- Load DA=4 with A=0x10; hold mem_ack low for 3 cycles, then mem_rdata=0xA5 -> in_ready=0 and mem_addr=0x10 throughout; R4=0xA5; flags unchanged.
- Store R5=0x3C at A=R6=0x20 -> mem_we=1, mem_wdata=0x3C; no register changes; assert rst during MEM_WAIT -> mem_req=0 immediately, state RUN.
- DATAPATH_PIPE_R0_ZERO_EN defined: write R0<-0xFF, then R1<-R0+1 -> R1=0x01.
